// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared constants and types for the ALU issue/writeback slice.
//             Holds the data/index widths, the 3-bit ALU opcode encoding and
//             the issue-stage FSM state type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int WIDTH     = 16;
    localparam int REG_IDX_W = 3;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        INC = 3'b010,
        DEC = 3'b011,
        AND = 3'b100,
        OR  = 3'b101,
        XOR = 3'b110,
        NOT = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : alu_regfile
//  Purpose  : NREGS x WIDTH register file, asynchronously cleared, with two
//             combinational read ports and one synchronous write port.
//  Ports    : clock, reset          - clock / async active-high clear
//             we, waddr, wdata      - write port (captured on rising edge)
//             raddr_a/rdata_a       - read port A (combinational)
//             raddr_b/rdata_b       - read port B (combinational)
//  Options  : ALU_ISSUE_R0_ZERO_EN  - r0 hardwired to zero (writes dropped)
//  Revision : 1.0  initial release
// ============================================================================
module alu_regfile #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    import alu_pkg::*;

`ifdef ALU_ISSUE_R0_ZERO_EN
    localparam bit c_R0_ZERO = 1'b1;
`else
    localparam bit c_R0_ZERO = 1'b0;
`endif

    logic [WIDTH-1:0] w_rf [NREGS];

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (c_R0_ZERO && (i == 0)) begin : g_zero
            // No storage: reads of r0 are constant zero, writes vanish.
            assign w_rf[i] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (we && (waddr == IDX_W'(i))) begin
                    r_q <= wdata;
                end
            end
            assign w_rf[i] = r_q;
        end
    end

    assign rdata_a = w_rf[raddr_a];
    assign rdata_b = w_rf[raddr_b];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Purpose  : Issue/writeback stage in front of a combinational 16-bit ALU.
//             Accepts one instruction per handshake, reads two operands from
//             the register file, presents them to the ALU for one EXEC cycle,
//             writes the result back and updates zero/negative flags. An
//             immediate-load instruction bypasses the ALU.
//  Ports    : clock, reset                 - clock / async active-high reset
//             in_valid, in_ready           - instruction handshake
//             in_load, in_opcode, in_rd,
//             in_rs1, in_rs2, in_imm       - instruction fields
//             alu_a, alu_b, alu_opcode     - drive to the ALU
//             alu_out                      - combinational ALU result
//             wb_valid, wb_rd, wb_data     - writeback report (1-cycle pulse)
//             flag_zero, flag_neg          - flags of the last ALU result
//  Options  : ALU_ISSUE_R0_ZERO_EN  - r0 hardwired to zero (in alu_regfile)
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue #(
    parameter  int WIDTH = alu_pkg::WIDTH,
    parameter  int NREGS = 8,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic [2:0]       in_opcode,
    input  logic [IDX_W-1:0] in_rd,
    input  logic [IDX_W-1:0] in_rs1,
    input  logic [IDX_W-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    output logic             wb_valid,
    output logic [IDX_W-1:0] wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             flag_zero,
    output logic             flag_neg
);

    import alu_pkg::*;

    state_t           r_state;
    logic [2:0]       r_opcode;
    logic [IDX_W-1:0] r_rd;
    logic [IDX_W-1:0] r_rs1;
    logic [IDX_W-1:0] r_rs2;
    logic             r_wb_valid;
    logic [IDX_W-1:0] r_wb_rd;
    logic [WIDTH-1:0] r_wb_data;
    logic             r_flag_zero;
    logic             r_flag_neg;

    logic             w_accept;
    logic             w_we;
    logic [IDX_W-1:0] w_waddr;
    logic [WIDTH-1:0] w_wdata;

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready;

    // Single write port shared by the load path (written on the accept edge
    // straight from the instruction fields) and the ALU path (written on the
    // edge that ends EXEC).
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_rd;
        w_wdata = alu_out;
        case (r_state)
            IDLE: begin
                if (w_accept && in_load) begin
                    w_we    = 1'b1;
                    w_waddr = in_rd;
                    w_wdata = in_imm;
                end
            end
            EXEC:    w_we = 1'b1;
            default: ;
        endcase
    end

    // Operand reads always follow the latched indices; the ALU result is only
    // consumed in EXEC, before the write edge, so rd == rs sees the old value.
    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .raddr_a (r_rs1),
        .rdata_a (alu_a),
        .raddr_b (r_rs2),
        .rdata_b (alu_b)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_flag_zero <= 1'b0;
            r_flag_neg  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opcode <= in_opcode;
                        r_rd     <= in_rd;
                        r_rs1    <= in_rs1;
                        r_rs2    <= in_rs2;
                        if (in_load) begin
                            // Loads report immediately and leave the flags alone.
                            r_wb_data  <= in_imm;
                            r_wb_rd    <= in_rd;
                            r_wb_valid <= 1'b1;
                            r_state    <= WB;
                        end else begin
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_wb_data   <= alu_out;
                    r_wb_rd     <= r_rd;
                    r_wb_valid  <= 1'b1;
                    r_flag_zero <= (alu_out == '0);
                    r_flag_neg  <= alu_out[WIDTH-1];
                    r_state     <= WB;
                end
                WB: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_opcode = r_opcode;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign flag_zero  = r_flag_zero;
    assign flag_neg   = r_flag_neg;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue
//  Purpose  : Self-checking bench for alu_issue. A behavioural ALU drives
//             alu_out; directed vectors come from a table, followed by
//             hand-written back-to-back, reset-abort and r0 sequences, then
//             random instructions checked against a register-file model.
//  Options  : ALU_ISSUE_R0_ZERO_EN  - expectations follow the r0 option
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_load;
    logic [2:0]  in_opcode;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic [15:0] in_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_out;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        flag_zero;
    logic        flag_neg;

    int n_checks = 0;
    int n_errors = 0;
    int wb_pulses = 0;
    int exp_pulses = 0;

    // Reference model state
    logic [15:0] m_rf [8];
    logic        m_z;
    logic        m_n;

    alu_issue dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_load    (in_load),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flag_zero  (flag_zero),
        .flag_neg   (flag_neg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a + 16'd1;
            3'd3:    return a - 16'd1;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign alu_out = alu_f(alu_opcode, alu_a, alu_b);

    always @(negedge clock) if (wb_valid) wb_pulses++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] idx);
`ifdef ALU_ISSUE_R0_ZERO_EN
        if (idx == 3'd0) return 16'h0;
`endif
        return m_rf[idx];
    endfunction

    function automatic void m_write(input logic [2:0] idx, input logic [15:0] v);
`ifdef ALU_ISSUE_R0_ZERO_EN
        if (idx == 3'd0) return;
`endif
        m_rf[idx] = v;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_z = 1'b0;
        m_n = 1'b0;
    endfunction

    // Applies one instruction to the model and returns what the DUT should show.
    function automatic void model_step(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm,
                                       output logic [15:0] ea, output logic [15:0] eb,
                                       output logic [15:0] ed, output logic ez, output logic en);
        ea = m_read(rs1);
        eb = m_read(rs2);
        if (ld) begin
            ed = imm;
        end else begin
            ed  = alu_f(op, ea, eb);
            m_z = (ed == 16'h0);
            m_n = ed[15];
        end
        m_write(rd, ed);
        ez = m_z;
        en = m_n;
    endfunction

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic run_instr(input string tag, input logic ld, input logic [2:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm,
                             input logic [15:0] ea, input logic [15:0] eb,
                             input logic [15:0] ed, input logic ez, input logic en);
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_load = ld; in_opcode = op;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (!ld) begin
            check({tag, " exec_a"}, 32'(alu_a), 32'(ea));
            check({tag, " exec_b"}, 32'(alu_b), 32'(eb));
            check({tag, " exec_op"}, 32'(alu_opcode), 32'(op));
            check({tag, " exec_busy"}, {30'd0, in_ready, wb_valid}, 32'd0);
            @(posedge clock); #1;
        end
        exp_pulses++;
        check({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, " wb_rd"}, 32'(wb_rd), 32'(rd));
        check({tag, " wb_data"}, 32'(wb_data), 32'(ed));
        check({tag, " flags"}, {30'd0, flag_zero, flag_neg}, {30'd0, ez, en});
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic        ld;
        logic [2:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] imm;
        logic [15:0] ea, eb, ed;
        logic        ez, en;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [15:0] ea, eb, ed, last_wb;
        logic        ez, en;
        int          acc, ready_low;
        int          acc_cyc [2];

        //               ld  op    rd    rs1   rs2   imm       a         b         data      z     n
        vecs[0]  = '{1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0, 16'h0, 16'h0005, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 16'h0003, 16'h0, 16'h0, 16'h0003, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 3'd3, 3'd1, 3'd2, 16'h0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'd1, 3'd4, 3'd2, 3'd1, 16'h0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 3'd6, 3'd5, 3'd1, 3'd1, 16'h0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 3'd0, 3'd7, 3'd0, 3'd0, 16'h8000, 16'h0, 16'h0, 16'h8000, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 3'd7, 3'd6, 3'd7, 3'd0, 16'h0, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'd4, 3'd6, 3'd7, 3'd4, 16'h0, 16'h8000, 16'hFFFE, 16'h8000, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 3'd2, 3'd1, 3'd1, 3'd0, 16'h0, 16'h0005, 16'h0000, 16'h0006, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'd5, 3'd2, 3'd1, 3'd2, 16'h0, 16'h0006, 16'h0003, 16'h0007, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'd2, 3'd4, 3'd3, 3'd3, 16'h0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 3'd3, 3'd5, 3'd5, 3'd5, 16'h0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_opcode = 3'd0;
        in_rd = 3'd0; in_rs1 = 3'd0; in_rs2 = 3'd0; in_imm = 16'h0;
        m_clear();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        // Reset state
        check("rst ready", 32'(in_ready), 32'd1);
        check("rst wb_valid", 32'(wb_valid), 32'd0);
        check("rst flags", {30'd0, flag_zero, flag_neg}, 32'd0);
        check("rst opcode", 32'(alu_opcode), 32'd0);
        check("rst operands", {alu_a, alu_b}, 32'd0);
        check("rst wb", {13'd0, wb_rd, wb_data}, 32'd0);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            model_step(vecs[i].ld, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, ea, eb, ed, ez, en);
            run_instr($sformatf("vec%0d", i), vecs[i].ld, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                      vecs[i].imm, vecs[i].ea, vecs[i].eb, vecs[i].ed, vecs[i].ez, vecs[i].en);
        end

        // Back-to-back: r1=6, r2=7 -> r3 = 0x000D, then r4 = r3 + r3 = 0x001A
        model_step(1'b0, 3'd0, 3'd3, 3'd1, 3'd2, 16'h0, ea, eb, ed, ez, en);
        model_step(1'b0, 3'd0, 3'd4, 3'd3, 3'd3, 16'h0, ea, eb, ed, ez, en);
        in_valid = 1'b1; in_load = 1'b0; in_opcode = 3'd0;
        in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
        acc = 0; ready_low = 0; last_wb = 16'hDEAD;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        for (int c = 0; c < 12 && acc < 2; c++) begin
            if (in_ready) begin
                acc_cyc[acc] = c;
                acc++;
            end else begin
                ready_low++;
            end
            @(posedge clock); #1;
            if (wb_valid) last_wb = wb_data;
            if (acc == 1) begin
                in_rd = 3'd4; in_rs1 = 3'd3; in_rs2 = 3'd3;
            end
            if (acc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        exp_pulses += 2;
        check("b2b accepts", 32'(acc), 32'd2);
        check("b2b spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check("b2b ready_low", 32'(ready_low), 32'd2);
        check("b2b first_wb", 32'(last_wb), 32'h000D);
        check("b2b fwd_a", 32'(alu_a), 32'h000D);
        @(posedge clock); #1;
        check("b2b second_wb", {15'd0, wb_valid, wb_data}, {15'd0, 1'b1, 16'h001A});
        @(posedge clock); #1;

        // Reset during EXEC of INC r6
        in_valid = 1'b1; in_load = 1'b0; in_opcode = 3'd2;
        in_rd = 3'd6; in_rs1 = 3'd6; in_rs2 = 3'd0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("abort in_exec", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("abort reset_ready", 32'(in_ready), 32'd1);
        check("abort reset_wb", 32'(wb_valid), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        m_clear();
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("abort pulses", 32'(wb_pulses), 32'(exp_pulses));
        check("abort flags", {30'd0, flag_zero, flag_neg}, 32'd0);
        model_step(1'b0, 3'd0, 3'd2, 3'd6, 3'd0, 16'h0, ea, eb, ed, ez, en);
        run_instr("abort r6", 1'b0, 3'd0, 3'd2, 3'd6, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);

        // r0 behaviour
        model_step(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 16'h1234, ea, eb, ed, ez, en);
        run_instr("r0 load", 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 16'h1234, ea, eb, 16'h1234, 1'b1, 1'b0);
        model_step(1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 16'h0, ea, eb, ed, ez, en);
`ifdef ALU_ISSUE_R0_ZERO_EN
        run_instr("r0 add", 1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
`else
        run_instr("r0 add", 1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 16'h0, 16'h1234, 16'h1234, 16'h2468, 1'b0, 1'b0);
`endif

        // Random instructions against the model
        for (int i = 0; i < 60; i++) begin
            logic        ld;
            logic [2:0]  op, rd, rs1, rs2;
            logic [15:0] imm;
            ld  = ($urandom_range(0, 3) == 0);
            op  = 3'($urandom_range(0, 7));
            rd  = 3'($urandom_range(0, 7));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       imm = 16'h0000;
                1:       imm = 16'h8000;
                default: imm = 16'($urandom);
            endcase
            model_step(ld, op, rd, rs1, rs2, imm, ea, eb, ed, ez, en);
            run_instr($sformatf("rnd%0d", i), ld, op, rd, rs1, rs2, imm, ea, eb, ed, ez, en);
        end

        repeat (2) @(posedge clock);
        #1;
        check("total pulses", 32'(wb_pulses), 32'(exp_pulses));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
